// File: rtl/mc_alu.sv
// -----------------------------------------------------------------------------
// mc_alu -- multi-cycle ALU with valid/ready handshakes on both sides.
//
// Single-cycle operations (logic, add/sub, set-less-than, shifts) are computed
// combinationally from the request and registered on the accept edge, so the
// result appears one cycle after accept. MUL uses a shift-add loop that
// consumes one multiplier bit per cycle for WIDTH cycles. The result is held
// until it is consumed, and a new request is taken only after that.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : synchronous active-high reset, wins over every other event
//   in_valid   : request valid
//   in_ready   : block is idle and can accept a request (registered)
//   a, b       : operands (b[SHW-1:0] is the shift amount for shifts)
//   f          : 4-bit operation code
//   out_valid  : result valid (registered)
//   out_ready  : consumer takes the result
//   y          : registered result
//   zero       : registered flag, y == 0
//   carry      : registered adder carry-out (ADD/SUB only, else 0)
//   overflow   : registered signed overflow (ADD/SUB only, else 0)
// -----------------------------------------------------------------------------
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_ANDN = 4'b0100;
    localparam logic [3:0] OP_ORN  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT2 = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    state_e            state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  y_q;
    logic              zero_q;
    logic              carry_q;
    logic              ovf_q;
    logic [CW-1:0]     cnt_q;

    // Multiplier datapath: shifted multiplicand, shifted multiplier, partial sum.
    logic [WIDTH-1:0]  mul_a_q;
    logic [WIDTH-1:0]  mul_b_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;

    // Single-cycle ALU results, valid while a request is presented.
    logic              adder_inv;
    logic [WIDTH-1:0]  b_x;
    logic [WIDTH:0]    sum_ext;
    logic              add_cout;
    logic              add_ovf;
    logic              slt_bit;
    logic [SHW-1:0]    shamt;
    logic [WIDTH-1:0]  y_d;
    logic              carry_d;
    logic              ovf_d;

    logic              accept;

    assign accept = in_valid & in_ready_q;

    // -------------------------------------------------------------------------
    // Shared adder and single-cycle operation select
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case below can leave a signal unassigned and infer a latch.
        y_d     = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;

        // All compare codes end in 11 and need a subtract; SUB has f[2] set.
        // The reserved 1111 also lands here, but its result is forced to 0.
        adder_inv = f[2] | (f[1:0] == 2'b11);
        b_x       = b ^ {WIDTH{adder_inv}};
        sum_ext   = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, adder_inv};
        add_cout  = sum_ext[WIDTH];
        // Carry into the MSB is recovered from the MSB sum bit.
        add_ovf   = (a[WIDTH-1] ^ b_x[WIDTH-1] ^ sum_ext[WIDTH-1]) ^ add_cout;
        slt_bit   = sum_ext[WIDTH-1] ^ add_ovf;
        shamt     = b[SHW-1:0];

        case (f)
            OP_AND:  y_d = a & b;
            OP_OR:   y_d = a | b;
            OP_ADD,
            OP_SUB: begin
                y_d     = sum_ext[WIDTH-1:0];
                carry_d = add_cout;
                ovf_d   = add_ovf;
            end
            OP_SLT,
            OP_SLT2: y_d = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_ANDN: y_d = a & ~b;
            OP_ORN:  y_d = a | ~b;
            OP_SLL:  y_d = a << shamt;
            OP_SRL:  y_d = a >> shamt;
            OP_SRA:  y_d = $unsigned($signed(a) >>> shamt);
            // A borrow shows up as a missing carry out of a + ~b + 1.
            OP_SLTU: y_d = {{(WIDTH-1){1'b0}}, ~add_cout};
            default: y_d = '0;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set. Bits beyond WIDTH fall off, leaving the low product.
    always_comb begin
        acc_d = acc_q;
        if (mul_b_q[0]) begin
            acc_d = acc_q + mul_a_q;
        end
    end

    // -------------------------------------------------------------------------
    // Multiplier datapath registers
    // -------------------------------------------------------------------------
    // NOTE: these registers carry no reset; they are always loaded on accept
    // before they are read, and the FSM decides whether their value is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            mul_a_q <= a;
            mul_b_q <= b;
            acc_q   <= '0;
        end else if (state_q == S_MUL) begin
            mul_a_q <= mul_a_q << 1;
            mul_b_q <= mul_b_q >> 1;
            acc_q   <= acc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake and result outputs
    // -------------------------------------------------------------------------
    // The opcode need not be stored for MUL: being in S_MUL implies it.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (f == OP_MUL) begin
                            state_q <= S_MUL;
                            cnt_q   <= '0;
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            y_q         <= y_d;
                            zero_q      <= (y_d == '0);
                            carry_q     <= carry_d;
                            ovf_q       <= ovf_d;
                        end
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q + 1'b1;
                    // The last of WIDTH iterations also writes the result.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        y_q         <= acc_d;
                        zero_q      <= (acc_d == '0);
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                    end
                end
                S_DONE: begin
                    // in_ready rises only on the cycle after the consume.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
